lap_stopwatch: RTL and testbench
================================

# lap_stopwatch

Parametrised multi-digit decimal stopwatch for the FPGA board: N BCD digits, programmable tick period, start/stop and lap/clear buttons, and direct 7-segment outputs. It is the next-generation timer block. All logic is fully synchronous to `clk`, with no divided or derived clocks. Key debounce/edge detection and optional wrap or saturate overflow handling are built in. It sits between the raw board keys and the HEX displays.

## Interface
- `DIGITS`, 3: number of BCD digits; digit 0 is least significant (one tick).
- `CLK_PER_TICK`, 5000000: clk cycles per count tick (50 MHz × 100 ms).
- `DEBOUNCE_CYCLES`, 1000000: lockout after an accepted press; 0 disables the lockout.
- `WRAP`, 1: 1 = wrap to all-zero on overflow; 0 = saturate at all-nines and stop.
- `SEG_ACTIVE_LOW`, 1: 1 = segment outputs inverted (DE-board HEX style).
- Ports:
  - `clk  in  1`: system clock.
  - `rst  in  1`: reset, synchronous, active-high.
  - `key_start_n  in  1`: raw async button, active-low; start/stop.
  - `key_lap_n  in  1`: raw async button, active-low; lap/clear.
  - `seg  out  7*DIGITS`: segments {g,f,e,d,c,b,a} per digit; digit i at `[7i+6:7i]`.
  - `running  out  1`: high in RUN or LAP.
  - `lap_active  out  1`: high in LAP (display frozen).
  - `overflow  out  1`: sticky; set when the count passes all-nines.

## Operation
- **Key path (per key):**
  - 2-flop synchroniser, then falling-edge detect.
  - Produces a 1-cycle `press` pulse.
  - After an accepted press, further edges on that key are ignored for `DEBOUNCE_CYCLES` cycles.
- **Prescaler:**
  - Counts 0..`CLK_PER_TICK`-1 while in RUN or LAP.
  - Holds its value in STOP, so fractional time is preserved.
  - Cleared in IDLE.
  - `tick` is asserted in the cycle the prescaler equals `CLK_PER_TICK`-1.
- **Counter:**
  - `DIGITS` cascaded BCD digits.
  - On `tick`, digit 0 increments; digit i+1 increments when digits 0..i are all 9; a digit at 9 rolls to 0.
  - Digit values never leave 0..9.
- **Overflow** (tick while all digits are 9):
  - `WRAP`=1: count becomes all 0 and `overflow` is set; state is unchanged.
  - `WRAP`=0: count holds at all 9, `overflow` is set, and the FSM goes to STOP.
- **FSM states:** IDLE, RUN, STOP, LAP. Reset state is IDLE.
  - start press: IDLE→RUN, RUN→STOP, STOP→RUN, LAP→STOP (display returns to live count).
  - lap press:
    - RUN→LAP: capture the current count into the lap register.
    - LAP→RUN: release the display.
    - STOP→IDLE: clear count, prescaler and `overflow`.
    - IDLE: no effect.
  - In STOP after saturation (`WRAP`=0), a start press →RUN; the count stays saturated, and each further tick re-stops.
- **Display source:** lap register in LAP, live count otherwise.
  - Each digit is decoded to 7 segments using the standard 0–9 patterns.
  - Output is inverted when `SEG_ACTIVE_LOW`=1.
  - `seg` is registered.
- **Simultaneous events:**
  - start and lap presses in the same cycle: start wins and lap is dropped.
  - tick and start press in the same cycle: the tick is applied, then the state changes; the count includes that tick.
  - tick in the capture cycle: the lap register captures the pre-tick count.
  - lap press in LAP together with a tick: the display resumes showing the post-tick count.

## Timing
- **Reset:** `rst` high at a clk edge puts the block in the following state at the next cycle:
  - IDLE, count 0, lap register 0, prescaler 0, debounce counters 0, synchronisers at 1.
  - `running`=0, `lap_active`=0, `overflow`=0.
  - `seg` = all digits showing "0" (0x40 per digit when active-low).
  - Reset mid-run takes effect immediately, with no pending tick.
- **Key latency:** key sampled low at edge k → `press` at edge k+2 → state/flags update at edge k+3.
- **Tick to display:** count updates at the edge ending the `tick` cycle; `seg` reflects it one cycle later.
- **Tick period:** first tick after IDLE→RUN occurs `CLK_PER_TICK` cycles after the RUN entry edge.
- **Flag timing:** `running`, `lap_active` and `overflow` are registered and change in the same cycle as the state/count.

## Test plan
1. **Plain run.** `DIGITS`=3, `CLK_PER_TICK`=10, `DEBOUNCE_CYCLES`=0: press start, wait 125 cycles → count 012, `running`=1, `seg[6:0]`=0x24 ("2", active-low).
2. **Stop/resume.**
   - Press start at 5 ticks + 4 cycles → count 005, stays stable for 100 cycles.
   - Press start again → 005→006 after exactly 6 more cycles.
   - Press lap while stopped → IDLE, all digits "0".
3. **Lap freeze.**
   - Lap press at count 007 → `seg` frozen at 007 while the internal count reaches 015.
   - Second lap press → `seg` shows 015 within 1 cycle.
4. **Overflow.**
   - `WRAP`=1 at 999 + tick → 000, `overflow`=1, `running`=1.
   - `WRAP`=0 at 999 + tick → 999, `overflow`=1, state STOP.
5. **Debounce.** `DEBOUNCE_CYCLES`=50: start key bounces (toggles every 3 cycles for 30 cycles) → exactly one start accepted. A second press after 60 cycles → accepted (STOP).
6. **Reset and conflicts.**
   - `rst` pulse mid-RUN at count 042 → next cycle count 000, IDLE, `seg` = "000".
   - start and lap pressed in the same cycle from IDLE → RUN, `lap_active`=0.

Source files
------------

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: multi-digit BCD stopwatch with start/stop, lap freeze and
// registered 7-segment outputs. Two raw active-low keys are synchronised,
// edge-detected and locked out for a programmable time after each press.

module lap_stopwatch #(
  parameter int unsigned DIGITS          = 3,
  parameter int unsigned CLK_PER_TICK    = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          WRAP            = 1'b1,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_start_n,
  input  logic                key_lap_n,
  output logic [7*DIGITS-1:0] seg,
  output logic                running,
  output logic                lap_active,
  output logic                overflow
);

  localparam int unsigned PreW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_TICK - 1);
  localparam logic [DbW-1:0]  DbLoad = DbW'(DEBOUNCE_CYCLES);
  localparam logic [6:0]      SegZeroDigit = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  typedef enum logic [1:0] {StIdle, StRun, StStop, StLap} state_e;
  typedef logic [DIGITS-1:0][3:0] count_t;

  // Standard 0-9 patterns, bit order {g,f,e,d,c,b,a}; optional inversion.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Key path: index 0 = start, index 1 = lap.
  logic [1:0]     w_key_n;
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_prev;
  logic [1:0]     r_press;
  logic [DbW-1:0] r_db [2];
  logic           w_start;
  logic           w_lap;

  // Core state.
  state_e          r_state;
  state_e          w_state_d;
  count_t          r_count;
  count_t          w_count_d;
  count_t          r_lap;
  count_t          w_lap_d;
  count_t          w_inc;
  count_t          w_disp;
  logic [PreW-1:0] r_pre;
  logic [PreW-1:0] w_pre_d;
  logic            r_ovf;
  logic            w_ovf_d;
  logic            w_tick;
  logic            w_carry;
  logic            w_all_nine;
  logic            r_running;
  logic            r_lap_active;
  logic [7*DIGITS-1:0] r_seg;
  logic [7*DIGITS-1:0] w_seg;

  assign w_key_n = {key_lap_n, key_start_n};

  // Synchronise, detect falling edges and apply the post-press lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_prev  <= 2'b11;
      r_press <= 2'b00;
      r_db[0] <= '0;
      r_db[1] <= '0;
    end else begin
      r_sync1 <= w_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      for (int k = 0; k < 2; k++) begin
        r_press[k] <= 1'b0;
        if (r_db[k] != '0) begin
          r_db[k] <= r_db[k] - DbW'(1);
        end else if (r_prev[k] && !r_sync2[k]) begin
          r_press[k] <= 1'b1;
          r_db[k]    <= DbLoad;
        end
      end
    end
  end

  // Start wins when both keys fire in the same cycle.
  assign w_start = r_press[0];
  assign w_lap   = r_press[1] & ~r_press[0];

  assign w_tick = ((r_state == StRun) || (r_state == StLap)) && (r_pre == PreMax);

  // Cascaded BCD increment; the final carry means every digit was 9.
  always_comb begin
    w_inc   = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[i] == 4'd9) begin
          w_inc[i] = 4'd0;
        end else begin
          w_inc[i] = r_count[i] + 4'd1;
          w_carry  = 1'b0;
        end
      end
    end
  end

  assign w_all_nine = w_carry;

  // Next state, count, prescaler, lap register and overflow flag.
  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_lap_d   = r_lap;
    w_ovf_d   = r_ovf;
    w_pre_d   = r_pre;

    unique case (r_state)
      StRun, StLap: w_pre_d = w_tick ? '0 : r_pre + PreW'(1);
      StStop:       w_pre_d = r_pre;
      StIdle:       w_pre_d = '0;
    endcase

    // The tick is applied first; any key-driven transition sees the ticked count.
    if (w_tick) begin
      if (!w_all_nine) begin
        w_count_d = w_inc;
      end else begin
        w_ovf_d = 1'b1;
        if (WRAP) w_count_d = w_inc;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StRun;
      end
      StRun: begin
        if (w_start) begin
          w_state_d = StStop;
        end else if (w_lap) begin
          w_state_d = StLap;
          w_lap_d   = r_count;  // pre-tick value
        end
      end
      StStop: begin
        if (w_start) begin
          w_state_d = StRun;
        end else if (w_lap) begin
          w_state_d = StIdle;
          w_count_d = '0;
          w_pre_d   = '0;
          w_ovf_d   = 1'b0;
        end
      end
      StLap: begin
        if (w_start) begin
          w_state_d = StStop;
        end else if (w_lap) begin
          w_state_d = StRun;
        end
      end
    endcase

    // Saturating mode: a tick at all-nines always parks the block in STOP.
    if (!WRAP && w_tick && w_all_nine) w_state_d = StStop;
  end

  // State, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_lap        <= '0;
      r_pre        <= '0;
      r_ovf        <= 1'b0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_count      <= w_count_d;
      r_lap        <= w_lap_d;
      r_pre        <= w_pre_d;
      r_ovf        <= w_ovf_d;
      r_running    <= (w_state_d == StRun) || (w_state_d == StLap);
      r_lap_active <= (w_state_d == StLap);
    end
  end

  // Display source: frozen lap value in LAP, live count otherwise.
  always_comb begin
    w_disp = (r_state == StLap) ? r_lap : r_count;
    w_seg  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_seg[7*i +: 7] = seg7(w_disp[i]);
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= {DIGITS{SegZeroDigit}};
    end else begin
      r_seg <= w_seg;
    end
  end

  assign seg        = r_seg;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: three instances (wrap, saturate, long lockout) share
// the keys and reset; an integer-arithmetic timeline model predicts every output.

module tb_lap_stopwatch;

  localparam int Cpt   = 10;
  localparam int MaxV  = 999;
  localparam int SIdle = 0;
  localparam int SRun  = 1;
  localparam int SStop = 2;
  localparam int SLap  = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ks_n = 1'b1;
  logic kl_n = 1'b1;

  logic [2:0][20:0] seg_p;
  logic [2:0]       run_p;
  logic [2:0]       lapa_p;
  logic [2:0]       ovf_p;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.DIGITS(3), .CLK_PER_TICK(10), .DEBOUNCE_CYCLES(0), .WRAP(1'b1),
                  .SEG_ACTIVE_LOW(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .key_start_n(ks_n), .key_lap_n(kl_n), .seg(seg_p[0]),
    .running(run_p[0]), .lap_active(lapa_p[0]), .overflow(ovf_p[0]));

  lap_stopwatch #(.DIGITS(3), .CLK_PER_TICK(10), .DEBOUNCE_CYCLES(0), .WRAP(1'b0),
                  .SEG_ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .key_start_n(ks_n), .key_lap_n(kl_n), .seg(seg_p[1]),
    .running(run_p[1]), .lap_active(lapa_p[1]), .overflow(ovf_p[1]));

  lap_stopwatch #(.DIGITS(3), .CLK_PER_TICK(10), .DEBOUNCE_CYCLES(50), .WRAP(1'b1),
                  .SEG_ACTIVE_LOW(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .key_start_n(ks_n), .key_lap_n(kl_n), .seg(seg_p[2]),
    .running(run_p[2]), .lap_active(lapa_p[2]), .overflow(ovf_p[2]));

  // Reference model state, one slot per instance.
  int cfg_wrap [3] = '{1, 0, 1};
  int cfg_db   [3] = '{0, 0, 50};
  int m_st  [3];
  int m_cnt [3];
  int m_lap [3];
  int m_pre [3];
  int m_ovf [3];
  int m_ps  [3];
  int m_pl  [3];
  int m_ls  [3];
  int m_ll  [3];
  logic [20:0] m_seg [3];
  // Raw key levels seen at the previous three edges (1 = released).
  bit hs1, hs2, hs3, hl1, hl2, hl3;
  int cyc = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F};

  function automatic logic [20:0] enc(input int v);
    logic [20:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 3; d++) begin
      r[7*d +: 7] = ~pat[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int dec(input logic [20:0] s);
    int v;
    int mult;
    int j;
    v = 0;
    mult = 1;
    for (int d = 0; d < 3; d++) begin
      j = -1;
      for (int k = 0; k < 10; k++) if (s[7*d +: 7] === ~pat[k]) j = k;
      if (j < 0) return -1;
      v = v + j * mult;
      mult = mult * 10;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_st[i] = SIdle; m_cnt[i] = 0; m_lap[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
        m_ps[i] = 0; m_pl[i] = 0; m_ls[i] = -1000000; m_ll[i] = -1000000;
        m_seg[i] = enc(0);
      end
      hs1 = 1; hs2 = 1; hs3 = 1; hl1 = 1; hl2 = 1; hl3 = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit st, lp, tick, fs, fl;
        int os, oc, ns;
        st = (m_ps[i] != 0);
        lp = (m_pl[i] != 0) && !st;
        // A key low at edge k becomes a press acting at edge k+3.
        fs = hs3 && !hs2;
        fl = hl3 && !hl2;
        m_ps[i] = 0;
        if (fs && (cyc - m_ls[i] > cfg_db[i])) begin m_ps[i] = 1; m_ls[i] = cyc; end
        m_pl[i] = 0;
        if (fl && (cyc - m_ll[i] > cfg_db[i])) begin m_pl[i] = 1; m_ll[i] = cyc; end

        os = m_st[i];
        oc = m_cnt[i];
        ns = os;
        m_seg[i] = enc((os == SLap) ? m_lap[i] : oc);
        tick = ((os == SRun) || (os == SLap)) && (m_pre[i] == Cpt - 1);
        if ((os == SRun) || (os == SLap)) m_pre[i] = tick ? 0 : m_pre[i] + 1;
        else if (os == SIdle) m_pre[i] = 0;
        if (tick) begin
          if (oc == MaxV) begin
            m_ovf[i] = 1;
            if (cfg_wrap[i] != 0) m_cnt[i] = 0;
          end else begin
            m_cnt[i] = oc + 1;
          end
        end
        case (os)
          SIdle: if (st) ns = SRun;
          SRun: begin
            if (st) ns = SStop;
            else if (lp) begin ns = SLap; m_lap[i] = oc; end
          end
          SStop: begin
            if (st) ns = SRun;
            else if (lp) begin ns = SIdle; m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0; end
          end
          default: begin
            if (st) ns = SStop;
            else if (lp) ns = SRun;
          end
        endcase
        if (tick && (oc == MaxV) && (cfg_wrap[i] == 0)) ns = SStop;
        m_st[i] = ns;
      end
      hs3 = hs2; hs2 = hs1; hs1 = ks_n;
      hl3 = hl2; hl2 = hl1; hl1 = kl_n;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seg%0d", i), 32'(seg_p[i]), 32'(m_seg[i]));
      check($sformatf("running%0d", i), 32'(run_p[i]),
            32'((m_st[i] == SRun) || (m_st[i] == SLap)));
      check($sformatf("lap_active%0d", i), 32'(lapa_p[i]), 32'(m_st[i] == SLap));
      check($sformatf("overflow%0d", i), 32'(ovf_p[i]), 32'(m_ovf[i] != 0));
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic press(input bit s, input bit l, input int hold);
    if (s) ks_n = 1'b0;
    if (l) kl_n = 1'b0;
    cyc_wait(hold);
    ks_n = 1'b1;
    kl_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
    cyc_wait(1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc_wait(1);
    check("reset_seg", 32'(seg_p[0]), 32'h0010_2040);
    check("reset_running", 32'(run_p[0]), 32'd0);

    // Plain run: 125 cycles after the press shows 012.
    do_reset();
    press(1'b1, 1'b0, 4);
    cyc_wait(121);
    check("plain_count", 32'(dec(seg_p[0])), 32'd12);
    check("plain_running", 32'(run_p[0]), 32'd1);
    check("plain_seg_d0", 32'(seg_p[0][6:0]), 32'h24);

    // Stop at 5 ticks + 4 cycles, hold, resume 6 cycles to the next tick, clear.
    do_reset();
    press(1'b1, 1'b0, 4);
    cyc_wait(50);
    press(1'b1, 1'b0, 4);
    cyc_wait(100);
    check("stop_hold", 32'(dec(seg_p[0])), 32'd5);
    check("stop_running", 32'(run_p[0]), 32'd0);
    press(1'b1, 1'b0, 4);
    cyc_wait(5);
    check("resume_before", 32'(dec(seg_p[0])), 32'd5);
    cyc_wait(2);
    check("resume_after", 32'(dec(seg_p[0])), 32'd6);
    press(1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 4);
    cyc_wait(2);
    check("clear_seg", 32'(seg_p[0]), 32'h0010_2040);

    // Lap freeze at 007 while the count runs to 015, then release.
    do_reset();
    press(1'b1, 1'b0, 4);
    cyc_wait(70);
    press(1'b0, 1'b1, 4);
    cyc_wait(80);
    check("lap_frozen", 32'(dec(seg_p[0])), 32'd7);
    check("lap_active", 32'(lapa_p[0]), 32'd1);
    press(1'b0, 1'b1, 4);
    cyc_wait(1);
    check("lap_release", 32'(dec(seg_p[0])), 32'd15);

    // Bouncing start key: one press accepted with a 50-cycle lockout.
    do_reset();
    for (int j = 0; j < 10; j++) begin
      ks_n = (j % 2 == 1);
      cyc_wait(3);
    end
    ks_n = 1'b1;
    cyc_wait(10);
    check("bounce_one_press", 32'(run_p[2]), 32'd1);
    cyc_wait(20);
    press(1'b1, 1'b0, 4);
    check("bounce_second_press", 32'(run_p[2]), 32'd0);

    // Reset mid-run at 042; then start and lap together from IDLE.
    do_reset();
    press(1'b1, 1'b0, 4);
    cyc_wait(425);
    check("pre_reset_count", 32'(dec(seg_p[0])), 32'd42);
    rst = 1'b1;
    cyc_wait(1);
    check("midrun_reset_seg", 32'(seg_p[0]), 32'h0010_2040);
    check("midrun_reset_running", 32'(run_p[0]), 32'd0);
    rst = 1'b0;
    cyc_wait(1);
    press(1'b1, 1'b1, 4);
    check("both_keys_running", 32'(run_p[0]), 32'd1);
    check("both_keys_lap", 32'(lapa_p[0]), 32'd0);
    cyc_wait(2);

    // Overflow: wrap versus saturate after 1000 ticks.
    do_reset();
    press(1'b1, 1'b0, 4);
    cyc_wait(10004);
    check("wrap_count", 32'(dec(seg_p[0])), 32'd0);
    check("wrap_overflow", 32'(ovf_p[0]), 32'd1);
    check("wrap_running", 32'(run_p[0]), 32'd1);
    check("sat_count", 32'(dec(seg_p[1])), 32'd999);
    check("sat_overflow", 32'(ovf_p[1]), 32'd1);
    check("sat_running", 32'(run_p[1]), 32'd0);
    press(1'b1, 1'b0, 4);
    check("sat_restart", 32'(run_p[1]), 32'd1);
    cyc_wait(15);
    check("sat_restop", 32'(run_p[1]), 32'd0);
    check("sat_still_999", 32'(dec(seg_p[1])), 32'd999);

    // Randomised key traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press(1'b1, 1'b0, int'($urandom_range(1, 8)));
        4, 5, 6:    press(1'b0, 1'b1, int'($urandom_range(1, 8)));
        7:          press(1'b1, 1'b1, int'($urandom_range(1, 4)));
        8: begin
          if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1;
            cyc_wait(1);
            rst = 1'b0;
          end
        end
        default: begin
          for (int j = 0; j < 6; j++) begin
            ks_n = $urandom_range(0, 1) != 0;
            kl_n = $urandom_range(0, 1) != 0;
            cyc_wait(1);
          end
          ks_n = 1'b1;
          kl_n = 1'b1;
        end
      endcase
      cyc_wait(int'($urandom_range(1, 40)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
